// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - merged card/PIN, menu and withdrawal session controller
// One registered FSM between the keypad/button debouncers and the display/dispenser drivers.
module atm_session_ctrl #(
  parameter int unsigned             PIN_DIGITS = 4,
  parameter logic [4*PIN_DIGITS-1:0] PIN_CODE   = 16'h1234,
  parameter int unsigned             MAX_TRIES  = 3,
  parameter int unsigned             BAL_W      = 16,
  parameter int unsigned             INIT_BAL   = 1000,
  parameter int unsigned             N_OPT      = 5,
  parameter int unsigned             AMT_STEP   = 100,
  parameter int unsigned             TIMEOUT    = 1000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             card_in,
  input  logic                             key_valid,
  input  logic [3:0]                       key_digit,
  input  logic                             key_back,
  input  logic                             btn_consult,
  input  logic                             btn_withdraw,
  input  logic [N_OPT-1:0]                 amt_sel,
  input  logic                             btn_yes,
  input  logic                             btn_no,
  output logic                             req_card,
  output logic                             req_pin,
  output logic                             menu_on,
  output logic                             select_on,
  output logic                             ask_other,
  output logic                             bal_valid,
  output logic [BAL_W-1:0]                 balance,
  output logic                             dispense,
  output logic [BAL_W-1:0]                 disp_amt,
  output logic                             denied,
  output logic                             eject,
  output logic                             retained,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries
);

  localparam int unsigned PW  = 4 * PIN_DIGITS;
  localparam int unsigned CW  = $clog2(PIN_DIGITS + 1);
  localparam int unsigned TW  = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PIN, S_MENU, S_SELECT, S_ANOTHER, S_EJECT, S_WAIT_REMOVE, S_LOCK
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    pin_q, pin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [BAL_W-1:0] amt_q, amt_d;
  logic [TMW-1:0]   timer_q, timer_d;

  logic req_card_q, req_pin_q, menu_on_q, select_on_q, ask_other_q, retained_q;
  logic bal_valid_q, dispense_q, denied_q, eject_q;
  logic bal_valid_d, dispense_d, denied_d;

  logic [PW-1:0]    pin_shift;
  logic [TW-1:0]    tries_inc;
  logic [BAL_W-1:0] sel_amt;
  logic             sel_ok;
  logic             any_strobe;
  logic             active;

  always_comb begin
    pin_shift  = PW'({pin_q, key_digit});
    tries_inc  = (tries_q == TW'(MAX_TRIES)) ? tries_q : tries_q + TW'(1);
    sel_ok     = $onehot(amt_sel);
    sel_amt    = '0;
    for (int k = 0; k < int'(N_OPT); k++) begin
      if (amt_sel[k]) sel_amt = BAL_W'((k + 1) * AMT_STEP);
    end
    any_strobe = key_valid | key_back | btn_consult | btn_withdraw | (|amt_sel) | btn_yes | btn_no;
    active     = (state_q == S_PIN) || (state_q == S_MENU) ||
                 (state_q == S_SELECT) || (state_q == S_ANOTHER);
  end

  always_comb begin
    state_d     = state_q;
    pin_d       = pin_q;
    cnt_d       = cnt_q;
    tries_d     = tries_q;
    bal_d       = bal_q;
    amt_d       = amt_q;
    timer_d     = '0;
    bal_valid_d = 1'b0;
    dispense_d  = 1'b0;
    denied_d    = 1'b0;

    // A pulled card aborts the session silently; nothing else in that cycle counts.
    if (active && !card_in) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (card_in) begin
            state_d = S_PIN;
            pin_d   = '0;
            cnt_d   = '0;
            tries_d = '0;
          end
        end
        S_PIN: begin
          if (key_valid) begin
            pin_d = pin_shift;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(PIN_DIGITS - 1)) begin
              pin_d = '0;
              cnt_d = '0;
              if (pin_shift == PIN_CODE) begin
                state_d = S_MENU;
                tries_d = '0;
              end else begin
                tries_d = tries_inc;
                if (tries_inc == TW'(MAX_TRIES)) state_d = S_LOCK;
              end
            end
          end else if (key_back) begin
            state_d = S_EJECT;
          end
        end
        S_MENU: begin
          if (btn_consult && !btn_withdraw) begin
            bal_valid_d = 1'b1;
            state_d     = S_ANOTHER;
          end else if (btn_withdraw && !btn_consult) begin
            state_d = S_SELECT;
          end else if (key_back) begin
            state_d = S_EJECT;
          end
        end
        S_SELECT: begin
          if (sel_ok) begin
            state_d = S_ANOTHER;
            if (sel_amt <= bal_q) begin
              bal_d      = bal_q - sel_amt;
              amt_d      = sel_amt;
              dispense_d = 1'b1;
            end else begin
              denied_d = 1'b1;
            end
          end else if (key_back) begin
            state_d = S_MENU;
          end
        end
        S_ANOTHER: begin
          if (btn_yes && !btn_no)      state_d = S_MENU;
          else if (btn_no && !btn_yes) state_d = S_EJECT;
        end
        S_EJECT:       state_d = S_WAIT_REMOVE;
        S_WAIT_REMOVE: if (!card_in) state_d = S_IDLE;
        S_LOCK:        state_d = S_LOCK;
      endcase

      // Inactivity only advances while the state holds and no strobe arrives.
      if (active && (state_d == state_q) && !any_strobe) begin
        if (timer_q == TMW'(TIMEOUT - 1)) state_d = S_EJECT;
        else                              timer_d = timer_q + TMW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pin_q       <= '0;
      cnt_q       <= '0;
      tries_q     <= '0;
      bal_q       <= BAL_W'(INIT_BAL);
      amt_q       <= '0;
      timer_q     <= '0;
      req_card_q  <= 1'b1;
      req_pin_q   <= 1'b0;
      menu_on_q   <= 1'b0;
      select_on_q <= 1'b0;
      ask_other_q <= 1'b0;
      retained_q  <= 1'b0;
      bal_valid_q <= 1'b0;
      dispense_q  <= 1'b0;
      denied_q    <= 1'b0;
      eject_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pin_q       <= pin_d;
      cnt_q       <= cnt_d;
      tries_q     <= tries_d;
      bal_q       <= bal_d;
      amt_q       <= amt_d;
      timer_q     <= timer_d;
      req_card_q  <= (state_d == S_IDLE);
      req_pin_q   <= (state_d == S_PIN);
      menu_on_q   <= (state_d == S_MENU);
      select_on_q <= (state_d == S_SELECT);
      ask_other_q <= (state_d == S_ANOTHER);
      retained_q  <= (state_d == S_LOCK);
      bal_valid_q <= bal_valid_d;
      dispense_q  <= dispense_d;
      denied_q    <= denied_d;
      eject_q     <= (state_d == S_EJECT);
    end
  end

  assign req_card  = req_card_q;
  assign req_pin   = req_pin_q;
  assign menu_on   = menu_on_q;
  assign select_on = select_on_q;
  assign ask_other = ask_other_q;
  assign retained  = retained_q;
  assign bal_valid = bal_valid_q;
  assign dispense  = dispense_q;
  assign denied    = denied_q;
  assign eject     = eject_q;
  assign balance   = bal_q;
  assign disp_amt  = amt_q;
  assign tries     = tries_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - self-checking bench for atm_session_ctrl
// Directed session scenarios followed by random traffic, all checked against a session model.
module tb_atm_session_ctrl;

  localparam int              PIN_DIGITS = 4;
  localparam logic [15:0]     PIN_CODE   = 16'h1234;
  localparam int              MAX_TRIES  = 3;
  localparam int              BAL_W      = 16;
  localparam int              INIT_BAL   = 500;
  localparam int              N_OPT      = 5;
  localparam int              AMT_STEP   = 100;
  localparam int              TIMEOUT    = 16;
  localparam int              TW         = $clog2(MAX_TRIES + 1);

  localparam int M_IDLE = 0, M_PIN = 1, M_MENU = 2, M_SEL = 3, M_ANOT = 4,
                 M_EJ = 5, M_WREM = 6, M_LOCK = 7;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             card_in = 1'b0;
  logic             key_valid = 1'b0;
  logic [3:0]       key_digit = 4'd0;
  logic             key_back = 1'b0;
  logic             btn_consult = 1'b0;
  logic             btn_withdraw = 1'b0;
  logic [N_OPT-1:0] amt_sel = '0;
  logic             btn_yes = 1'b0;
  logic             btn_no = 1'b0;
  logic             req_card, req_pin, menu_on, select_on, ask_other, bal_valid;
  logic [BAL_W-1:0] balance, disp_amt;
  logic             dispense, denied, eject, retained;
  logic [TW-1:0]    tries;

  atm_session_ctrl #(
    .PIN_DIGITS(PIN_DIGITS), .PIN_CODE(PIN_CODE), .MAX_TRIES(MAX_TRIES), .BAL_W(BAL_W),
    .INIT_BAL(INIT_BAL), .N_OPT(N_OPT), .AMT_STEP(AMT_STEP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .card_in(card_in), .key_valid(key_valid), .key_digit(key_digit),
    .key_back(key_back), .btn_consult(btn_consult), .btn_withdraw(btn_withdraw),
    .amt_sel(amt_sel), .btn_yes(btn_yes), .btn_no(btn_no), .req_card(req_card),
    .req_pin(req_pin), .menu_on(menu_on), .select_on(select_on), .ask_other(ask_other),
    .bal_valid(bal_valid), .balance(balance), .dispense(dispense), .disp_amt(disp_amt),
    .denied(denied), .eject(eject), .retained(retained), .tries(tries)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Session model: where the customer is, what the account holds, and pulses due this cycle.
  int m_st, m_bal, m_tries, m_disp, m_idle;
  bit m_bv, m_dp, m_dn;
  int m_digits[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_bal = INIT_BAL; m_tries = 0; m_disp = 0; m_idle = 0;
    m_bv = 0; m_dp = 0; m_dn = 0;
    m_digits.delete();
  endtask

  function automatic bit in_session(input int st);
    return (st == M_PIN) || (st == M_MENU) || (st == M_SEL) || (st == M_ANOT);
  endfunction

  task automatic model_step();
    bit strobe;
    int nxt, pinval, amt, hot, idx;
    strobe = key_valid || key_back || btn_consult || btn_withdraw || (amt_sel != 0) || btn_yes || btn_no;
    nxt = m_st; m_bv = 0; m_dp = 0; m_dn = 0;
    if (in_session(m_st) && !card_in) begin
      nxt = M_IDLE;
    end else begin
      if (m_st == M_IDLE && card_in) begin
        nxt = M_PIN; m_digits.delete(); m_tries = 0;
      end else if (m_st == M_PIN) begin
        if (key_valid) begin
          m_digits.push_back(int'(key_digit));
          if (m_digits.size() == PIN_DIGITS) begin
            pinval = 0;
            foreach (m_digits[i]) pinval = pinval * 16 + m_digits[i];
            m_digits.delete();
            if (pinval == int'(PIN_CODE)) begin
              nxt = M_MENU; m_tries = 0;
            end else begin
              if (m_tries < MAX_TRIES) m_tries++;
              if (m_tries == MAX_TRIES) nxt = M_LOCK;
            end
          end
        end else if (key_back) nxt = M_EJ;
      end else if (m_st == M_MENU) begin
        if (btn_consult && !btn_withdraw) begin m_bv = 1; nxt = M_ANOT; end
        else if (btn_withdraw && !btn_consult) nxt = M_SEL;
        else if (key_back) nxt = M_EJ;
      end else if (m_st == M_SEL) begin
        hot = 0; idx = 0;
        for (int k = 0; k < N_OPT; k++) if (amt_sel[k]) begin hot++; idx = k; end
        if (hot == 1) begin
          amt = ((idx + 1) * AMT_STEP) % (1 << BAL_W);
          if (amt <= m_bal) begin m_bal -= amt; m_disp = amt; m_dp = 1; end
          else m_dn = 1;
          nxt = M_ANOT;
        end else if (key_back) nxt = M_MENU;
      end else if (m_st == M_ANOT) begin
        if (btn_yes && !btn_no) nxt = M_MENU;
        else if (btn_no && !btn_yes) nxt = M_EJ;
      end else if (m_st == M_EJ) begin
        nxt = M_WREM;
      end else if (m_st == M_WREM && !card_in) begin
        nxt = M_IDLE;
      end
    end
    if (in_session(m_st) && nxt == m_st && card_in) begin
      if (strobe) m_idle = 0;
      else if (m_idle == TIMEOUT - 1) begin nxt = M_EJ; m_idle = 0; end
      else m_idle++;
    end else begin
      m_idle = 0;
    end
    m_st = nxt;
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("req_card",  req_card,  m_st == M_IDLE);
      check("req_pin",   req_pin,   m_st == M_PIN);
      check("menu_on",   menu_on,   m_st == M_MENU);
      check("select_on", select_on, m_st == M_SEL);
      check("ask_other", ask_other, m_st == M_ANOT);
      check("eject",     eject,     m_st == M_EJ);
      check("retained",  retained,  m_st == M_LOCK);
      check("bal_valid", bal_valid, m_bv);
      check("dispense",  dispense,  m_dp);
      check("denied",    denied,    m_dn);
      check("balance",   balance,   m_bal);
      check("disp_amt",  disp_amt,  m_disp);
      check("tries",     tries,     m_tries);
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk); #2;
    key_valid = 0; key_back = 0; btn_consult = 0; btn_withdraw = 0;
    amt_sel = '0; btn_yes = 0; btn_no = 0;
  endtask

  task automatic enter_pin(input logic [15:0] code);
    for (int i = PIN_DIGITS - 1; i >= 0; i--) begin
      key_valid = 1; key_digit = code[4*i +: 4];
      tick();
    end
  endtask

  task automatic do_reset();
    key_valid = 0; key_back = 0; btn_consult = 0; btn_withdraw = 0;
    amt_sel = '0; btn_yes = 0; btn_no = 0;
    reset = 0;
    model_reset();
    #1;
    check("rst_req_card", req_card, 1);
    check("rst_select_on", select_on, 0);
    check("rst_balance", balance, INIT_BAL);
    check("rst_dispense", dispense, 0);
    @(posedge clk); #2;
    reset = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    @(posedge clk); #2;
    model_reset();
    chk_en = 1;
    @(posedge clk); #2;
    check("init_req_card", req_card, 1);
    check("init_balance", balance, 500);
    check("init_pulses", {bal_valid, dispense, denied, eject}, 0);
    reset = 1;

    // Consult balance, decline, take card.
    card_in = 1; tick();
    check("pin_prompt", req_pin, 1);
    enter_pin(16'h1234);
    check("menu_after_pin", menu_on, 1);
    check("tries_after_pin", tries, 0);
    btn_consult = 1; tick();
    check("consult_pulse", bal_valid, 1);
    check("consult_balance", balance, 500);
    check("consult_ask", ask_other, 1);
    btn_no = 1; tick();
    check("no_eject", eject, 1);
    tick();
    card_in = 0; tick();
    check("removed_idle", req_card, 1);

    // Withdraw 300, then a denied 400.
    card_in = 1; tick();
    enter_pin(16'h1234);
    btn_withdraw = 1; tick();
    check("select_on", select_on, 1);
    amt_sel = 5'b00100; tick();
    check("disp_pulse", dispense, 1);
    check("disp_amt_300", disp_amt, 300);
    check("bal_200", balance, 200);
    btn_yes = 1; tick();
    check("yes_menu", menu_on, 1);
    btn_withdraw = 1; tick();
    amt_sel = 5'b01000; tick();
    check("denied_pulse", denied, 1);
    check("denied_bal", balance, 200);
    check("denied_disp_hold", disp_amt, 300);
    btn_no = 1; tick(); tick();
    card_in = 0; tick();

    // Three wrong PINs retain the card.
    card_in = 1; tick();
    enter_pin(16'h1111); check("tries_1", tries, 1); check("still_pin", req_pin, 1);
    enter_pin(16'h1111); check("tries_2", tries, 2);
    enter_pin(16'h1111); check("tries_3", tries, 3); check("locked", retained, 1);
    card_in = 0; tick();
    card_in = 1; key_valid = 1; key_digit = 4'd1; tick();
    check("lock_holds", retained, 1);
    check("lock_no_card_prompt", req_card, 0);
    card_in = 0;
    do_reset();
    check("reset_bal_500", balance, 500);

    // Inactivity: 16 quiet MENU cycles, eject on the 17th.
    card_in = 1; tick();
    enter_pin(16'h1234);
    repeat (15) tick();
    check("menu_before_timeout", menu_on, 1);
    check("no_eject_yet", eject, 0);
    tick();
    check("timeout_eject", eject, 1);
    tick();
    card_in = 0; tick();
    card_in = 1; tick();
    enter_pin(16'h1234);
    btn_withdraw = 1; tick();
    amt_sel = 5'b00110; tick();
    check("multihot_ignored", select_on, 1);
    check("multihot_no_disp", dispense, 0);
    amt_sel = 5'b00001; tick();
    check("bal_400", balance, 400);
    btn_yes = 1; tick();
    btn_withdraw = 1; tick();
    check("select_again", select_on, 1);

    // Reset mid-withdraw, then card pulled during PIN entry.
    do_reset();
    tick();
    check("pin_after_reset", req_pin, 1);
    key_valid = 1; key_digit = 4'd1; tick();
    key_valid = 1; key_digit = 4'd2; key_back = 1; tick();
    check("key_beats_back", req_pin, 1);
    card_in = 0; tick();
    check("pulled_idle", req_card, 1);
    check("pulled_no_eject", eject, 0);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      if (m_st == M_LOCK && $urandom_range(0, 7) == 0) begin do_reset(); continue; end
      if (m_bal < 100 && $urandom_range(0, 40) == 0) begin do_reset(); continue; end
      if (m_st == M_IDLE || m_st == M_EJ || m_st == M_WREM) begin
        if ($urandom_range(0, 3) == 0) card_in = !card_in;
      end else if ($urandom_range(0, 120) == 0) begin
        card_in = 0;
      end
      if ($urandom_range(0, 60) == 0) begin
        repeat (TIMEOUT + 2) tick();
        continue;
      end
      r = $urandom_range(0, 23);
      if (r <= 5) begin
        key_valid = 1;
        if ($urandom_range(0, 99) < 93)
          key_digit = PIN_CODE[4*(PIN_DIGITS-1-(m_digits.size() % PIN_DIGITS)) +: 4];
        else
          key_digit = 4'($urandom_range(0, 9));
      end
      else if (r == 6)  key_back = 1;
      else if (r == 7)  begin key_valid = 1; key_back = 1; key_digit = 4'($urandom_range(0, 9)); end
      else if (r <= 9)  btn_consult = 1;
      else if (r <= 11) btn_withdraw = 1;
      else if (r == 12) begin btn_consult = 1; btn_withdraw = 1; end
      else if (r <= 14) amt_sel = N_OPT'(1 << $urandom_range(0, N_OPT - 1));
      else if (r == 15) amt_sel = N_OPT'($urandom_range(0, 31));
      else if (r == 16) btn_yes = 1;
      else if (r == 17) btn_no = 1;
      else if (r == 18) begin btn_yes = 1; btn_no = 1; end
      tick();
    end

    @(posedge clk); #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
